vga_value_scheduler: RTL and testbench
======================================

VGA_VALUE_SCHEDULER -- requirements
Module: vga_value_scheduler

Interface
REQ-001 SHALL have parameter: VSYNC_ACTIVE_LOW, 1, frame-start edge is the falling edge of vsync_in when 1, rising edge when 0.
REQ-002 SHALL have parameter: NUM_BITS, 8, width of each binary input value (fixed at 8 for this release).
REQ-003 SHALL have port: clk  in  1  pixel clock (25 MHz domain); one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: vsync_in  in  1  vertical sync from the sync generator, same clock domain.
REQ-006 SHALL have port: freeze  in  1  when 1, no new captures start (display holds).
REQ-007 SHALL have ports: x_value, y_value, z_value  in  8  unsigned binary sensor values.
REQ-008 SHALL have ports: x_bcd, y_bcd, z_bcd  out  12  {hundreds, tens, units}, 4 bits each.
REQ-009 SHALL have ports: x_show, y_show, z_show  out  3  digit-enable mask {hundreds, tens, units} for leading-zero blanking.
REQ-010 SHALL have port: busy  out  1  high while a capture/conversion is in progress.
REQ-011 SHALL have port: update_done  out  1  one-cycle pulse when new outputs are published.
REQ-012 SHALL have port: overrun  out  1  sticky; set when a frame-start edge arrives while busy.

Function
REQ-013 SHALL register vsync_in once (vsync_q); frame-start = (vsync_q, vsync_in) == (1,0) if VSYNC_ACTIVE_LOW, else (0,1).
REQ-014 SHALL implement FSM states IDLE, CONVERT, PUBLISH.
REQ-015 IDLE -> CONVERT on frame-start with freeze==0; same edge latches x/y/z_value into internal shadow registers and clears the channel index and bit counter.
REQ-016 CONVERT: one double-dabble step per clock (each BCD nibble >=5 gets +3, then shift left by one, taking the next shadow MSB); 8 steps per channel, channels in order X, Y, Z; 24 cycles total.
REQ-017 CONVERT -> PUBLISH on the clock edge that completes step 8 of channel Z.
REQ-018 PUBLISH -> IDLE after one cycle; on that edge all nine outputs (bcd, show) SHALL update simultaneously, and update_done SHALL be 1 for exactly the following cycle.
REQ-019 Latency: outputs change on edge k+25, where k is the frame-start detection edge.
REQ-020 show mask: bit0 always 1; bit1 = (value >= 10); bit2 = (value >= 100), computed from the latched value.
REQ-021 busy SHALL be 1 in CONVERT and PUBLISH and 0 in IDLE.
REQ-022 Frame-start while busy SHALL be ignored (no restart) and SHALL set overrun; only rst clears overrun.
REQ-023 Input changes after the latch edge SHALL NOT affect the in-flight result.
REQ-024 freeze rising mid-conversion SHALL NOT abort; the current update completes and publishes.
REQ-025 Outputs SHALL be stable between update_done pulses (no partial updates visible to the renderer).

Reset
REQ-026 On rst=1 at a clock edge: state IDLE; shadows, counters, vsync_q (to inactive level) cleared; x/y/z_bcd = 0; x/y/z_show = 3'b001; busy = 0; update_done = 0; overrun = 0.
REQ-027 rst mid-conversion SHALL abandon the conversion; no update_done pulse for it.

Structure
REQ-028 Shared package vga_text_pkg SHALL hold the FSM state encoding, BCD_DIGITS=3, NUM_CH=3, and BCD width constants.
REQ-029 One sub-module, bcd_dabble_step (combinational: 12-bit BCD + input bit -> adjusted-and-shifted 12-bit BCD), SHALL be instantiated once and shared across channels.

Verification
REQ-030 X=255, Y=0, Z=100, one frame-start -> after 25 clocks x_bcd=12'h255/show=111, y_bcd=12'h000/show=001, z_bcd=12'h100/show=111; update_done one cycle.
REQ-031 X=9, Y=10, Z=99 -> x_show=001, y_bcd=12'h010/show=011, z_bcd=12'h099/show=011.
REQ-032 Second frame-start 10 clocks after the first -> ignored, overrun=1, single update_done, results from the first latch.
REQ-033 Change X from 42 to 200 at cycle 5 of CONVERT -> x_bcd=12'h042; next frame yields 12'h200.
REQ-034 freeze=1 across three frame-starts -> no busy, no update_done, outputs unchanged.
REQ-035 rst asserted at CONVERT cycle 12 -> next cycle all outputs at reset values, busy=0, no update_done; next frame-start converts normally.

Source files
------------

// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared FSM encoding, BCD sizing and digit-blanking helper for the value scheduler
package vga_text_pkg;
    localparam int BCD_DIGITS = 3;
    localparam int NUM_CH = 3;
    localparam int DIGIT_W = 4;
    localparam int BCD_W = BCD_DIGITS * DIGIT_W;
    typedef enum logic [1:0] {IDLE, CONVERT, PUBLISH} state_t;
    function automatic logic [BCD_DIGITS-1:0] show_mask(input logic [7:0] v);
        return {v >= 8'd100, v >= 8'd10, 1'b1};
    endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration (add-3 on nibbles >= 5, then shift in the next binary bit)
module bcd_dabble_step
    import vga_text_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             bit_in,
    output logic [BCD_W-1:0] bcd_out
);
    logic [BCD_W-1:0] adj;
    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_dig
        assign adj[DIGIT_W*d +: DIGIT_W] = bcd_in[DIGIT_W*d +: DIGIT_W] >= 4'd5 ?
            bcd_in[DIGIT_W*d +: DIGIT_W] + 4'd3 : bcd_in[DIGIT_W*d +: DIGIT_W];
    end
    assign bcd_out = {adj[BCD_W-2:0], bit_in};
endmodule

// File: rtl/vga_value_scheduler.sv
// vga_value_scheduler: latches three values on frame start, converts them to BCD serially and publishes atomically
module vga_value_scheduler
    import vga_text_pkg::*;
#(
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter int NUM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vsync_in,
    input  logic                  freeze,
    input  logic [NUM_BITS-1:0]   x_value,
    input  logic [NUM_BITS-1:0]   y_value,
    input  logic [NUM_BITS-1:0]   z_value,
    output logic [BCD_W-1:0]      x_bcd,
    output logic [BCD_W-1:0]      y_bcd,
    output logic [BCD_W-1:0]      z_bcd,
    output logic [BCD_DIGITS-1:0] x_show,
    output logic [BCD_DIGITS-1:0] y_show,
    output logic [BCD_DIGITS-1:0] z_show,
    output logic                  busy,
    output logic                  update_done,
    output logic                  overrun
);
    localparam int CW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);
    state_t state_q, state_d;
    logic vsync_q;
    logic frame_start;
    logic [NUM_BITS-1:0] sh_q [NUM_CH];
    logic [NUM_BITS-1:0] sh_d [NUM_CH];
    logic [NUM_BITS-1:0] cur;
    logic [1:0] ch_q, ch_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [BCD_W-1:0] acc_q, acc_d, step_out;
    logic [BCD_W-1:0] res_q [NUM_CH];
    logic [BCD_W-1:0] res_d [NUM_CH];
    logic [BCD_W-1:0] bcd_q [NUM_CH];
    logic [BCD_W-1:0] bcd_d [NUM_CH];
    logic [BCD_DIGITS-1:0] show_q [NUM_CH];
    logic [BCD_DIGITS-1:0] show_d [NUM_CH];
    logic done_q, done_d;
    logic overrun_q, overrun_d;
    assign frame_start = VSYNC_ACTIVE_LOW ? (vsync_q & ~vsync_in) : (~vsync_q & vsync_in);
    assign cur = ch_q == 2'd0 ? sh_q[0] : ch_q == 2'd1 ? sh_q[1] : sh_q[2];
    bcd_dabble_step u_step (
        .bcd_in  (acc_q),
        .bit_in  (cur[LAST - bit_q]),
        .bcd_out (step_out)
    );
    always_comb begin
        state_d = state_q;
        sh_d = sh_q;
        ch_d = ch_q;
        bit_d = bit_q;
        acc_d = acc_q;
        res_d = res_q;
        bcd_d = bcd_q;
        show_d = show_q;
        done_d = 1'b0;
        overrun_d = overrun_q | (frame_start & (state_q != IDLE));
        if (state_q == IDLE && frame_start && !freeze) begin
            state_d = CONVERT;
            sh_d = '{x_value, y_value, z_value};
            ch_d = '0;
            bit_d = '0;
            acc_d = '0;
        end else if (state_q == CONVERT) begin
            acc_d = step_out;
            bit_d = bit_q + 1'b1;
            if (bit_q == LAST) begin
                acc_d = '0;
                bit_d = '0;
                ch_d = ch_q + 2'd1;
                for (int i = 0; i < NUM_CH; i++)
                    if (ch_q == 2'(i)) res_d[i] = step_out;
                if (ch_q == 2'(NUM_CH - 1)) state_d = PUBLISH;
            end
        end else if (state_q == PUBLISH) begin
            state_d = IDLE;
            done_d = 1'b1;
            bcd_d = res_q;
            for (int i = 0; i < NUM_CH; i++) show_d[i] = show_mask(sh_q[i]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vsync_q <= VSYNC_ACTIVE_LOW;
            sh_q <= '{default: '0};
            ch_q <= '0;
            bit_q <= '0;
            acc_q <= '0;
            res_q <= '{default: '0};
            bcd_q <= '{default: '0};
            show_q <= '{default: 3'b001};
            done_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync_in;
            sh_q <= sh_d;
            ch_q <= ch_d;
            bit_q <= bit_d;
            acc_q <= acc_d;
            res_q <= res_d;
            bcd_q <= bcd_d;
            show_q <= show_d;
            done_q <= done_d;
            overrun_q <= overrun_d;
        end
    end
    assign x_bcd = bcd_q[0];
    assign y_bcd = bcd_q[1];
    assign z_bcd = bcd_q[2];
    assign x_show = show_q[0];
    assign y_show = show_q[1];
    assign z_show = show_q[2];
    assign busy = state_q != IDLE;
    assign update_done = done_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_vga_value_scheduler.sv
// tb_vga_value_scheduler: directed vectors with hand-computed BCD, blanking, latency and overrun expectations
module tb_vga_value_scheduler;
    logic clk = 1'b0;
    logic rst, vsync_in, freeze;
    logic [7:0] x_value, y_value, z_value;
    logic [11:0] x_bcd, y_bcd, z_bcd;
    logic [2:0] x_show, y_show, z_show;
    logic busy, update_done, overrun;
    int errors = 0;
    int checks = 0;
    int n;
    vga_value_scheduler dut (
        .clk(clk), .rst(rst), .vsync_in(vsync_in), .freeze(freeze),
        .x_value(x_value), .y_value(y_value), .z_value(z_value),
        .x_bcd(x_bcd), .y_bcd(y_bcd), .z_bcd(z_bcd),
        .x_show(x_show), .y_show(y_show), .z_show(z_show),
        .busy(busy), .update_done(update_done), .overrun(overrun)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic pulse;
        @(negedge clk) vsync_in = 1'b0;
        @(negedge clk) vsync_in = 1'b1;
    endtask
    task automatic wait_done(output int cyc);
        logic [44:0] snap;
        logic moved;
        snap = {x_bcd, y_bcd, z_bcd, x_show, y_show, z_show};
        moved = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (update_done) break;
            if ({x_bcd, y_bcd, z_bcd, x_show, y_show, z_show} !== snap) moved = 1'b1;
        end
        chk("stable_before_done", moved, 0);
    endtask
    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (update_done) cnt++;
        end
    endtask
    task automatic chk_out(input string tag, input logic [11:0] xb, yb, zb, input logic [2:0] xs, ys, zs);
        chk({tag, "_x_bcd"}, x_bcd, xb);
        chk({tag, "_y_bcd"}, y_bcd, yb);
        chk({tag, "_z_bcd"}, z_bcd, zb);
        chk({tag, "_x_show"}, x_show, xs);
        chk({tag, "_y_show"}, y_show, ys);
        chk({tag, "_z_show"}, z_show, zs);
    endtask
    initial begin
        rst = 1'b1; vsync_in = 1'b1; freeze = 1'b0;
        x_value = 0; y_value = 0; z_value = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_out("reset", 12'h000, 12'h000, 12'h000, 3'b001, 3'b001, 3'b001);
        chk("reset_busy", busy, 0);
        chk("reset_done", update_done, 0);
        chk("reset_overrun", overrun, 0);
        x_value = 255; y_value = 0; z_value = 100;
        pulse();
        chk("t1_busy", busy, 1);
        wait_done(n);
        chk("t1_latency", n, 25);
        chk_out("t1", 12'h255, 12'h000, 12'h100, 3'b111, 3'b001, 3'b111);
        @(negedge clk);
        chk("t1_done_one_cycle", update_done, 0);
        chk("t1_idle", busy, 0);
        x_value = 9; y_value = 10; z_value = 99;
        pulse();
        wait_done(n);
        chk("t2_latency", n, 25);
        chk_out("t2", 12'h009, 12'h010, 12'h099, 3'b001, 3'b011, 3'b011);
        chk("t2_overrun", overrun, 0);
        x_value = 1; y_value = 2; z_value = 3;
        pulse();
        repeat (9) @(negedge clk);
        x_value = 7; y_value = 8; z_value = 9;
        pulse();
        chk("t3_overrun", overrun, 1);
        wait_done(n);
        chk("t3_latency", n, 14);
        chk_out("t3", 12'h001, 12'h002, 12'h003, 3'b001, 3'b001, 3'b001);
        count_done(30, n);
        chk("t3_single_done", n, 0);
        chk("t3_overrun_sticky", overrun, 1);
        x_value = 42; y_value = 0; z_value = 0;
        pulse();
        repeat (4) @(negedge clk);
        x_value = 200;
        wait_done(n);
        chk("t4_latency", n, 21);
        chk("t4_x_old", x_bcd, 12'h042);
        chk("t4_x_show_old", x_show, 3'b011);
        pulse();
        wait_done(n);
        chk("t4_x_new", x_bcd, 12'h200);
        chk("t4_x_show_new", x_show, 3'b111);
        freeze = 1'b1;
        x_value = 5; y_value = 123; z_value = 250;
        repeat (3) begin
            pulse();
            chk("t5_frozen_busy", busy, 0);
            repeat (3) @(negedge clk);
        end
        count_done(30, n);
        chk("t5_frozen_done", n, 0);
        chk_out("t5_frozen", 12'h200, 12'h000, 12'h000, 3'b111, 3'b001, 3'b001);
        freeze = 1'b0;
        pulse();
        repeat (3) @(negedge clk);
        freeze = 1'b1;
        wait_done(n);
        chk("t6_latency", n, 22);
        chk_out("t6", 12'h005, 12'h123, 12'h250, 3'b001, 3'b111, 3'b111);
        freeze = 1'b0;
        x_value = 77;
        pulse();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_out("t7_rst", 12'h000, 12'h000, 12'h000, 3'b001, 3'b001, 3'b001);
        chk("t7_busy", busy, 0);
        chk("t7_overrun", overrun, 0);
        count_done(30, n);
        chk("t7_no_done", n, 0);
        x_value = 128; y_value = 64; z_value = 32;
        pulse();
        wait_done(n);
        chk("t8_latency", n, 25);
        chk_out("t8", 12'h128, 12'h064, 12'h032, 3'b111, 3'b011, 3'b011);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
